axi_lite_cmd_master: RTL
========================

Name: axi_lite_cmd_master

Overview:
Synthesisable, parametrised AXI4-Lite master engine. It turns a simple valid/ready command stream into single AXI4-Lite read or write transactions and returns one response per command. It is the successor to the task-driven PCIe/AXI simulation master. Compared with that model, it adds independent AW/W handshaking, configurable address and data widths, byte strobes derived from DATA_W, a per-transaction timeout, and a back-pressured response channel. It sits between a control sequencer (or bench) and any axi4-lite slave in the fabric.

Parameters:
ADDR_W, 32, address width in bits
DATA_W, 32, data width in bits; must be 32 or 64; strobe width is DATA_W/8
TIMEOUT, 1024, max cycles waiting on any single AXI phase; 0 disables the timeout

Ports:
REFCLK  in  1  clock
reset  in  1  synchronous reset, active-high
cmd_valid  in  1  command valid
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_W  byte address
cmd_wdata  in  DATA_W  write data
cmd_wstrb  in  DATA_W/8  write byte strobes
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
rsp_rdata  out  DATA_W  read data (0 for writes)
rsp_resp  out  2  captured BRESP/RRESP, or 2'b10 on timeout
rsp_timeout  out  1  transaction aborted by timeout
m_axi_awaddr/awvalid/awready, wdata/wstrb/wvalid/wready, bresp/bvalid/bready, araddr/arvalid/arready, rdata/rresp/rvalid/rready  standard AXI4-Lite master signals, widths per ADDR_W/DATA_W; awprot/arprot tied 3'b000

Behaviour:
- Reset (synchronous, high):
  - State goes to IDLE.
  - All *valid, bready and rready outputs are 0.
  - cmd_ready = 0 while reset is high.
  - rsp_* outputs are 0; the timeout counter is 0.
  - Reset mid-transaction abandons it with no response.
- FSM states: IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, RESP.
- IDLE:
  - cmd_ready = 1.
  - On accept, the command is registered.
  - Next state is WR (awvalid = wvalid = 1 next cycle) or RD_ADDR (arvalid = 1 next cycle).
- WR:
  - AW and W are handshaked independently.
  - awvalid drops the cycle after its own awready handshake; wvalid likewise, tracked by aw_done and w_done flags.
  - When both are done (same or different cycles), go to WR_RESP.
- WR_RESP:
  - bready = 1.
  - On bvalid, capture bresp, set rsp_rdata = 0, go to RESP.
- RD_ADDR: arvalid held until arready, then go to RD_DATA.
- RD_DATA:
  - rready = 1.
  - On rvalid, capture rdata and rresp, go to RESP.
- RESP:
  - rsp_valid = 1, with payload stable, until rsp_ready.
  - Then return to IDLE; cmd_ready is 1 in the following cycle.
- Valids never depend combinationally on ready.
- Address and data are stable while valid is high.
- Latency, zero-wait slave, response on the cycle after address handshake:
  - Command accepted in cycle 0.
  - AXI valids high in cycle 1.
  - Response handshake in cycle 2.
  - rsp_valid high in cycle 3.
- Timeout:
  - A counter resets on entry to each of WR, WR_RESP, RD_ADDR and RD_DATA, and increments every cycle spent in that state.
  - On reaching TIMEOUT (when TIMEOUT != 0), all AXI valid/ready outputs are deasserted and the block goes to RESP with rsp_timeout = 1, rsp_resp = 2'b10 and rsp_rdata = 0.
  - Limitation (accepted, debug aid for dead slaves): a late B or R beat from an aborted transaction is not tracked.
- Only one outstanding transaction; cmd_ready = 0 outside IDLE.
- The counter saturates and never wraps.

Test Plan:
- Zero-wait slave, write addr 0x10, data 0xDEADBEEF, strb 0xF -> AW and W handshake in the same cycle; rsp_valid at cycle 3 with rsp_resp = 0 and rsp_timeout = 0.
- Slave asserts wready 4 cycles after awready -> awvalid drops after its own handshake; wvalid held until wready; exactly one B accepted; response returned.
- Read addr 0x20, slave returns rdata 0x12345678 with rresp = 2'b10 after 3 waits -> rsp_rdata = 0x12345678, rsp_resp = 2'b10.
- TIMEOUT = 8, slave never asserts arready -> arvalid high for exactly 8 cycles then drops; rsp_timeout = 1, rsp_resp = 2'b10.
- rsp_ready held low for 5 cycles -> rsp payload stable; cmd_ready stays 0; a new command is accepted only after the rsp handshake.
- Reset asserted while in WR_RESP -> all outputs 0 on the next edge; no rsp_valid; a following read completes normally.

Source files
------------

// File: rtl/axi_lite_cmd_master.sv
// AXI4-Lite master engine: one valid/ready command becomes one AXI4-Lite read or write,
// with one response per command and an optional per-phase timeout.
module axi_lite_cmd_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic                REFCLK,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_wstrb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [1:0]          rsp_resp,
  output logic                rsp_timeout,
  output logic [ADDR_W-1:0]   m_axi_awaddr,
  output logic [2:0]          m_axi_awprot,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  output logic [DATA_W-1:0]   m_axi_wdata,
  output logic [DATA_W/8-1:0] m_axi_wstrb,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  input  logic [1:0]          m_axi_bresp,
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready,
  output logic [ADDR_W-1:0]   m_axi_araddr,
  output logic [2:0]          m_axi_arprot,
  output logic                m_axi_arvalid,
  input  logic                m_axi_arready,
  input  logic [DATA_W-1:0]   m_axi_rdata,
  input  logic [1:0]          m_axi_rresp,
  input  logic                m_axi_rvalid,
  output logic                m_axi_rready
);
  // state   | meaning
  // IDLE    | ready for a command
  // WR      | AW and W in flight, handshaked independently
  // WR_RESP | waiting for B
  // RD_ADDR | AR in flight
  // RD_DATA | waiting for R
  // RESP    | response held until rsp_ready
  typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, RESP} state_t;

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_TC  = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   wstrb_q;
  logic                aw_done, w_done;
  logic [CNT_W-1:0]    cnt;
  logic                tmo, accept, aw_hs, w_hs;
  logic                cap_en, cap_to;
  logic [DATA_W-1:0]   cap_rdata;
  logic [1:0]          cap_resp;

  assign cmd_ready     = (state == IDLE) && !reset;
  assign accept        = cmd_valid && cmd_ready;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_awvalid = (state == WR) && !aw_done;
  assign m_axi_wvalid  = (state == WR) && !w_done;
  assign m_axi_bready  = (state == WR_RESP);
  assign m_axi_arvalid = (state == RD_ADDR);
  assign m_axi_rready  = (state == RD_DATA);
  assign rsp_valid     = (state == RESP);
  assign aw_hs         = m_axi_awvalid && m_axi_awready;
  assign w_hs          = m_axi_wvalid && m_axi_wready;
  // Terminal count is one below TIMEOUT so a phase stays visible for exactly TIMEOUT cycles.
  assign tmo           = (TIMEOUT != 0) && (cnt == CNT_TC);

  always_comb begin
    state_nxt = state;
    cap_en    = 1'b0;
    cap_to    = 1'b0;
    cap_rdata = '0;
    cap_resp  = 2'b00;
    case (state)
      IDLE: if (accept) state_nxt = cmd_write ? WR : RD_ADDR;
      WR: begin
        if ((aw_done || aw_hs) && (w_done || w_hs)) begin
          state_nxt = WR_RESP;
        end else if (tmo) begin
          state_nxt = RESP;
          cap_en    = 1'b1;
          cap_to    = 1'b1;
          cap_resp  = 2'b10;
        end
      end
      WR_RESP: begin
        if (m_axi_bvalid) begin
          state_nxt = RESP;
          cap_en    = 1'b1;
          cap_resp  = m_axi_bresp;
        end else if (tmo) begin
          state_nxt = RESP;
          cap_en    = 1'b1;
          cap_to    = 1'b1;
          cap_resp  = 2'b10;
        end
      end
      RD_ADDR: begin
        if (m_axi_arready) begin
          state_nxt = RD_DATA;
        end else if (tmo) begin
          state_nxt = RESP;
          cap_en    = 1'b1;
          cap_to    = 1'b1;
          cap_resp  = 2'b10;
        end
      end
      RD_DATA: begin
        if (m_axi_rvalid) begin
          state_nxt = RESP;
          cap_en    = 1'b1;
          cap_rdata = m_axi_rdata;
          cap_resp  = m_axi_rresp;
        end else if (tmo) begin
          state_nxt = RESP;
          cap_en    = 1'b1;
          cap_to    = 1'b1;
          cap_resp  = 2'b10;
        end
      end
      RESP: if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge REFCLK) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rsp_rdata   <= '0;
      rsp_resp    <= 2'b00;
      rsp_timeout <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) cnt <= '0;
      else if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
      if (accept) begin
        addr_q  <= cmd_addr;
        wdata_q <= cmd_wdata;
        wstrb_q <= cmd_wstrb;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end else begin
        if (aw_hs) aw_done <= 1'b1;
        if (w_hs)  w_done  <= 1'b1;
      end
      if (cap_en) begin
        rsp_rdata   <= cap_rdata;
        rsp_resp    <= cap_resp;
        rsp_timeout <= cap_to;
      end
    end
  end
endmodule
